// File: rtl/cache_way_policy.sv
// -----------------------------------------------------------------------------
// cache_way_policy
//
// N-way replacement and way-select unit for the set-associative cache
// datapath. Each set holds a tree-PLRU state (NUM_WAYS-1 bits) and an MRU way.
// A lookup returns a registered way index, one cycle later, chosen by mode:
//   cmp (00, and reserved 11) : lowest valid hitting way
//   lru (01)                  : lowest invalid way, else the PLRU victim
//   mru (10)                  : most recently touched way of the set
// A touch to the same set in the same cycle as a lookup is forwarded into
// that lookup. clear wipes PLRU, MRU and the sticky multi-hit error.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   lookup_valid/set, way_mode     lookup request
//   hit_vec, valid_vec             per-way tag-compare and valid bits
//   touch_valid/set/way            access record for replacement state
//   clear                          synchronous wipe of all policy state
//   resp_valid/way/hit/fill        registered response (held when idle)
//   err_multihit                   sticky multiple-valid-hit flag
// -----------------------------------------------------------------------------
module cache_way_policy #(
    parameter  int NUM_WAYS = 4,
    parameter  int NUM_SETS = 16,
    localparam int WAY_W    = $clog2(NUM_WAYS),
    localparam int SET_W    = $clog2(NUM_SETS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lookup_valid,
    input  logic [SET_W-1:0]    lookup_set,
    input  logic [1:0]          way_mode,
    input  logic [NUM_WAYS-1:0] hit_vec,
    input  logic [NUM_WAYS-1:0] valid_vec,
    input  logic                touch_valid,
    input  logic [SET_W-1:0]    touch_set,
    input  logic [WAY_W-1:0]    touch_way,
    input  logic                clear,
    output logic                resp_valid,
    output logic [WAY_W-1:0]    resp_way,
    output logic                resp_hit,
    output logic                resp_fill,
    output logic                err_multihit
);

    // Width of a heap node index; node indices run 0..NUM_WAYS-2.
    localparam int NODE_W = (NUM_WAYS > 2) ? $clog2(NUM_WAYS - 1) : 1;

    typedef logic [NUM_WAYS-2:0] tree_t;

    typedef enum logic [1:0] {
        MODE_CMP = 2'b00,
        MODE_LRU = 2'b01,
        MODE_MRU = 2'b10,
        MODE_RSV = 2'b11
    } way_mode_e;

    // ------------------------------------------------------------------
    // Tree helpers. The walk consumes way index bits MSB first; at each
    // node the next node is 2k+1 (left) or 2k+2 (right).
    // ------------------------------------------------------------------
    function automatic tree_t plru_touch(input tree_t t, input logic [WAY_W-1:0] way);
        tree_t             r;
        logic [NODE_W-1:0] k;
        r = t;
        k = '0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            // Point away from the touched way.
            r[k] = ~way[l];
            // The final step overflows past the last node; it is never used.
            k    = NODE_W'({k, 1'b1}) + NODE_W'(way[l]);
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input tree_t t);
        logic [WAY_W-1:0]  w;
        logic [NODE_W-1:0] k;
        w = '0;
        k = '0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            w[l] = t[k];
            k    = NODE_W'({k, 1'b1}) + NODE_W'(t[k]);
        end
        return w;
    endfunction

    function automatic logic [WAY_W-1:0] lowest_set(input logic [NUM_WAYS-1:0] v);
        logic [WAY_W-1:0] w;
        w = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (v[i]) w = WAY_W'(i);
        end
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Policy state
    // ------------------------------------------------------------------
    tree_t            plru [NUM_SETS];
    logic [WAY_W-1:0] mru  [NUM_SETS];

    // ------------------------------------------------------------------
    // Lookup selection (combinational, registered below)
    // ------------------------------------------------------------------
    logic [NUM_WAYS-1:0] m;
    tree_t               touched_tree;
    tree_t               eff_tree;
    logic [WAY_W-1:0]    eff_mru;
    logic                fwd;
    logic                is_cmp;
    logic [WAY_W-1:0]    sel_way;
    logic                sel_hit;
    logic                sel_fill;
    logic                multihit;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        m            = hit_vec & valid_vec;
        touched_tree = plru_touch(plru[touch_set], touch_way);
        // clear suppresses forwarding: the lookup sees pre-clear state.
        fwd          = touch_valid && !clear && (touch_set == lookup_set);
        eff_tree     = fwd ? touched_tree : plru[lookup_set];
        eff_mru      = fwd ? touch_way    : mru[lookup_set];
        is_cmp       = 1'b0;
        sel_way      = '0;
        sel_fill     = 1'b0;

        case (way_mode_e'(way_mode))
            MODE_LRU: begin
                if (&valid_vec) begin
                    sel_way = plru_victim(eff_tree);
                end else begin
                    sel_way  = lowest_set(~valid_vec);
                    sel_fill = 1'b1;
                end
            end
            MODE_MRU: sel_way = eff_mru;
            default: begin
                // cmp and the reserved encoding behave identically.
                is_cmp  = 1'b1;
                sel_way = lowest_set(m);
            end
        endcase

        sel_hit  = m[sel_way];
        // More than one bit set <=> clearing the lowest set bit leaves something.
        multihit = is_cmp && ((m & (m - NUM_WAYS'(1))) != '0);
    end

    // ------------------------------------------------------------------
    // State and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the policy arrays are flops, not RAM, and are reset because
            // the replacement order after reset is architecturally defined.
            for (int s = 0; s < NUM_SETS; s++) begin
                plru[s] <= '0;
                mru[s]  <= '0;
            end
            resp_valid   <= 1'b0;
            resp_way     <= '0;
            resp_hit     <= 1'b0;
            resp_fill    <= 1'b0;
            err_multihit <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so all reads in this block and in
            // the combinational logic see pre-edge state.
            if (clear) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    plru[s] <= '0;
                    mru[s]  <= '0;
                end
            end else if (touch_valid) begin
                plru[touch_set] <= touched_tree;
                mru[touch_set]  <= touch_way;
            end

            if (clear) begin
                err_multihit <= 1'b0;
            end else if (lookup_valid && multihit) begin
                err_multihit <= 1'b1;
            end

            resp_valid <= lookup_valid;
            if (lookup_valid) begin
                resp_way  <= sel_way;
                resp_hit  <= sel_hit;
                resp_fill <= sel_fill;
            end
        end
    end

endmodule

// File: tb/tb_cache_way_policy.sv
// -----------------------------------------------------------------------------
// tb_cache_way_policy
//
// Directed vector table for the documented scenarios, a hand-written
// asynchronous-reset sequence, then randomized traffic compared each cycle
// against a behavioural model of the policy (NUM_WAYS = 4, NUM_SETS = 16).
// Response compared as a packed {valid, way[1:0], hit, fill, err}.
// -----------------------------------------------------------------------------
module tb_cache_way_policy;

    localparam int NW = 4;
    localparam int NS = 16;
    localparam int WW = 2;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          lookup_valid;
    logic [SW-1:0] lookup_set;
    logic [1:0]    way_mode;
    logic [NW-1:0] hit_vec;
    logic [NW-1:0] valid_vec;
    logic          touch_valid;
    logic [SW-1:0] touch_set;
    logic [WW-1:0] touch_way;
    logic          clear;
    logic          resp_valid;
    logic [WW-1:0] resp_way;
    logic          resp_hit;
    logic          resp_fill;
    logic          err_multihit;

    int checks = 0;
    int errors = 0;

    cache_way_policy #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_set   (lookup_set),
        .way_mode     (way_mode),
        .hit_vec      (hit_vec),
        .valid_vec    (valid_vec),
        .touch_valid  (touch_valid),
        .touch_set    (touch_set),
        .touch_way    (touch_way),
        .clear        (clear),
        .resp_valid   (resp_valid),
        .resp_way     (resp_way),
        .resp_hit     (resp_hit),
        .resp_fill    (resp_fill),
        .err_multihit (err_multihit)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] dut_out();
        return {resp_valid, resp_way, resp_hit, resp_fill, err_multihit};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {v,way,hit,fill,err}=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                     name, act[5], act[4:3], act[2], act[1], act[0],
                     exp[5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: PLRU node at depth d on the path to way w is
    // heap node (2^d - 1) + (w >> (WW-d)); the direction taken there is
    // bit (WW-1-d) of w.
    // ------------------------------------------------------------------
    bit   m_tree [NS][NW-1];
    int   m_mru  [NS];
    logic e_valid, e_hit, e_fill, e_err;
    int   e_way;

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int n = 0; n < NW - 1; n++) m_tree[s][n] = 1'b0;
            m_mru[s] = 0;
        end
        e_valid = 0; e_way = 0; e_hit = 0; e_fill = 0; e_err = 0;
    endtask

    task automatic model_touch(input int s, input int w);
        for (int d = 0; d < WW; d++) begin
            int node = (1 << d) - 1 + (w >> (WW - d));
            int dir  = (w >> (WW - 1 - d)) & 1;
            m_tree[s][node] = (dir == 0);
        end
        m_mru[s] = w;
    endtask

    function automatic int model_victim(input int s);
        int w = 0;
        for (int d = 0; d < WW; d++) begin
            int node = (1 << d) - 1 + w;
            w = 2 * w + int'(m_tree[s][node]);
        end
        return w;
    endfunction

    function automatic int lowest_one(input logic [NW-1:0] v);
        for (int i = 0; i < NW; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Apply one cycle of the current DUT inputs to the model.
    task automatic model_cycle();
        logic [NW-1:0] m;
        bit            fwd;
        m   = hit_vec & valid_vec;
        fwd = touch_valid && !clear && (touch_set == lookup_set);
        if (fwd) model_touch(int'(touch_set), int'(touch_way));
        e_valid = lookup_valid;
        if (lookup_valid) begin
            e_fill = 0;
            if (way_mode == 2'b01) begin
                if (valid_vec != 4'b1111) begin
                    e_way  = lowest_one(~valid_vec);
                    e_fill = 1;
                end else begin
                    e_way = model_victim(int'(lookup_set));
                end
            end else if (way_mode == 2'b10) begin
                e_way = m_mru[int'(lookup_set)];
            end else begin
                e_way = lowest_one(m);
                if ($countones(m) > 1 && !clear) e_err = 1;
            end
            e_hit = m[e_way];
        end
        if (clear) begin
            for (int s = 0; s < NS; s++) begin
                for (int n = 0; n < NW - 1; n++) m_tree[s][n] = 1'b0;
                m_mru[s] = 0;
            end
            e_err = 0;
        end else if (touch_valid && !fwd) begin
            model_touch(int'(touch_set), int'(touch_way));
        end
    endtask

    function automatic logic [5:0] model_out();
        return {e_valid, 2'(e_way), e_hit, e_fill, e_err};
    endfunction

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    typedef struct {
        string      name;
        logic       tv;
        int         ts;
        int         tw;
        logic       lv;
        int         ls;
        logic [1:0] mode;
        logic [3:0] hit;
        logic [3:0] valid;
        logic       clr;
        logic [5:0] exp;   // {valid, way, hit, fill, err}
    } vec_t;

    vec_t tbl[$];

    task automatic drive_idle();
        lookup_valid = 0; lookup_set = '0; way_mode = 2'b00;
        hit_vec = '0; valid_vec = '0;
        touch_valid = 0; touch_set = '0; touch_way = '0; clear = 0;
    endtask

    task automatic drive_vec(input vec_t v);
        touch_valid  = v.tv;
        touch_set    = SW'(v.ts);
        touch_way    = WW'(v.tw);
        lookup_valid = v.lv;
        lookup_set   = SW'(v.ls);
        way_mode     = v.mode;
        hit_vec      = v.hit;
        valid_vec    = v.valid;
        clear        = v.clr;
    endtask

    initial begin
        //                name          tv ts tw  lv ls mode   hit      valid    clr  exp v_wy_h_f_e
        tbl.push_back('{"rst_lru",     0, 0, 0, 1, 5, 2'b01, 4'b0000, 4'b1111, 0, 6'b1_00_0_0_0});
        tbl.push_back('{"touch3_w0",   1, 3, 0, 0, 0, 2'b00, 4'b0000, 4'b0000, 0, 6'b0_00_0_0_0});
        tbl.push_back('{"touch3_w2",   1, 3, 2, 0, 0, 2'b00, 4'b0000, 4'b0000, 0, 6'b0_00_0_0_0});
        tbl.push_back('{"touch3_w1",   1, 3, 1, 0, 0, 2'b00, 4'b0000, 4'b0000, 0, 6'b0_00_0_0_0});
        tbl.push_back('{"touch3_w3",   1, 3, 3, 0, 0, 2'b00, 4'b0000, 4'b0000, 0, 6'b0_00_0_0_0});
        tbl.push_back('{"lru3_all",    0, 0, 0, 1, 3, 2'b01, 4'b0000, 4'b1111, 0, 6'b1_00_0_0_0});
        tbl.push_back('{"touch6_w0",   1, 6, 0, 0, 0, 2'b00, 4'b0000, 4'b0000, 0, 6'b0_00_0_0_0});
        tbl.push_back('{"touch6_w2",   1, 6, 2, 0, 0, 2'b00, 4'b0000, 4'b0000, 0, 6'b0_00_0_0_0});
        tbl.push_back('{"lru6_two",    0, 0, 0, 1, 6, 2'b01, 4'b0010, 4'b1111, 0, 6'b1_01_1_0_0});
        tbl.push_back('{"lru4_other",  0, 0, 0, 1, 4, 2'b01, 4'b0000, 4'b1111, 0, 6'b1_00_0_0_0});
        tbl.push_back('{"fwd_same",    1, 7, 0, 1, 7, 2'b01, 4'b0000, 4'b1111, 0, 6'b1_10_0_0_0});
        tbl.push_back('{"fwd_other",   1, 8, 0, 1, 9, 2'b01, 4'b0000, 4'b1111, 0, 6'b1_00_0_0_0});
        tbl.push_back('{"cmp_multi",   0, 0, 0, 1, 1, 2'b00, 4'b0110, 4'b1111, 0, 6'b1_01_1_0_1});
        tbl.push_back('{"err_sticky",  0, 0, 0, 0, 0, 2'b00, 4'b0000, 4'b0000, 0, 6'b0_01_1_0_1});
        tbl.push_back('{"clear_err",   0, 0, 0, 0, 0, 2'b00, 4'b0000, 4'b0000, 1, 6'b0_01_1_0_0});
        tbl.push_back('{"lru_fill",    0, 0, 0, 1, 0, 2'b01, 4'b0000, 4'b1011, 0, 6'b1_10_0_1_0});
        tbl.push_back('{"touch2_w3",   1, 2, 3, 0, 0, 2'b00, 4'b0000, 4'b0000, 0, 6'b0_10_0_1_0});
        tbl.push_back('{"mru2",        0, 0, 0, 1, 2, 2'b10, 4'b1000, 4'b1111, 0, 6'b1_11_1_0_0});
        tbl.push_back('{"touch6_w0b",  1, 6, 0, 0, 0, 2'b00, 4'b0000, 4'b0000, 0, 6'b0_11_1_0_0});
        tbl.push_back('{"clr_lookup",  1, 6, 1, 1, 6, 2'b01, 4'b0000, 4'b1111, 1, 6'b1_10_0_0_0});
        tbl.push_back('{"lru6_clrd",   0, 0, 0, 1, 6, 2'b01, 4'b0000, 4'b1111, 0, 6'b1_00_0_0_0});
        tbl.push_back('{"mru6_lost",   0, 0, 0, 1, 6, 2'b10, 4'b0001, 4'b1111, 0, 6'b1_00_1_0_0});
        tbl.push_back('{"clr_wins",    0, 0, 0, 1, 0, 2'b00, 4'b0011, 4'b0111, 1, 6'b1_00_1_0_0});
        tbl.push_back('{"rsv_cmp",     0, 0, 0, 1, 0, 2'b11, 4'b1100, 4'b0100, 0, 6'b1_10_1_0_0});
        tbl.push_back('{"cmp_miss",    0, 0, 0, 1, 0, 2'b00, 4'b0000, 4'b1111, 0, 6'b1_00_0_0_0});

        // -------- reset --------
        drive_idle();
        rst = 1'b1;
        #12;
        check("reset_state", dut_out(), 6'b0_00_0_0_0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // -------- directed table --------
        foreach (tbl[i]) begin
            drive_vec(tbl[i]);
            @(posedge clk); #1;
            check(tbl[i].name, dut_out(), tbl[i].exp);
        end
        drive_idle();

        // -------- asynchronous reset with a lookup pending --------
        touch_valid = 1; touch_set = 4'd5; touch_way = 2'd1;
        @(posedge clk); #1;
        drive_idle();
        lookup_valid = 1; lookup_set = 4'd5; way_mode = 2'b10;
        hit_vec = 4'b0010; valid_vec = 4'b1111;
        @(posedge clk); #1;
        check("pre_rst_mru5", dut_out(), 6'b1_01_1_0_0);
        lookup_valid = 1; way_mode = 2'b01;      // pending lookup
        #2 rst = 1'b1;
        #1 check("rst_immediate", dut_out(), 6'b0_00_0_0_0);
        @(posedge clk); #1;
        check("rst_no_pulse", dut_out(), 6'b0_00_0_0_0);
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", dut_out(), 6'b0_00_0_0_0);
        lookup_valid = 1; lookup_set = 4'd5; way_mode = 2'b10; valid_vec = 4'b1111;
        @(posedge clk); #1;
        check("rst_mru5_zero", dut_out(), 6'b1_00_0_0_0);
        way_mode = 2'b01;
        @(posedge clk); #1;
        check("rst_plru5_zero", dut_out(), 6'b1_00_0_0_0);
        drive_idle();
        @(posedge clk); #1;

        // -------- randomized traffic vs model --------
        model_reset();
        for (int c = 0; c < 600; c++) begin
            touch_valid  = ($urandom_range(0, 1) == 1);
            touch_set    = SW'($urandom_range(0, 3));
            touch_way    = WW'($urandom_range(0, NW - 1));
            lookup_valid = ($urandom_range(0, 3) != 0);
            lookup_set   = SW'($urandom_range(0, 3));
            way_mode     = 2'($urandom_range(0, 3));
            hit_vec      = NW'($urandom);
            valid_vec    = ($urandom_range(0, 1) == 1) ? 4'b1111 : NW'($urandom);
            clear        = ($urandom_range(0, 31) == 0);
            model_cycle();
            @(posedge clk); #1;
            check($sformatf("rand_%0d", c), dut_out(), model_out());
        end
        drive_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
